// File: rtl/riscv151_dbg_pkg.sv
// Shared encodings for the Riscv151 register-file debug responder.
package riscv151_dbg_pkg;

    localparam logic DBG_OP_READ    = 1'b0;
    localparam logic DBG_OP_WAIT_EQ = 1'b1;

    typedef enum logic [1:0] {
        DBG_OK      = 2'd0,
        DBG_MATCH   = 2'd1,
        DBG_TIMEOUT = 2'd2
    } dbg_status_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dbg_state_e;

endpackage

// File: rtl/shadow_regfile.sv
// Shadow copy of the CPU register file: one write port snooped from writeback,
// one read port that bypasses a same-cycle write. x0 always reads zero.
module shadow_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        if (raddr == '0)
            rdata = '0;
        else if (we && waddr == raddr)
            rdata = wdata;
        else
            rdata = mem[raddr];
    end

endmodule

// File: rtl/regfile_debug_responder.sv
// Host-facing debug responder: READ returns a shadowed register, WAIT_EQ
// blocks until a register holds a value or a cycle budget runs out.
module regfile_debug_responder
    import riscv151_dbg_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_we,
    input  logic [4:0]       wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [4:0]       req_reg,
    input  logic [XLEN-1:0]  req_value,
    input  logic [TMO_W-1:0] req_timeout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_data,
    output logic [1:0]       rsp_status
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and payload holds steady while valid is high.

    dbg_state_e       state, state_next;
    dbg_status_e      status_q, status_next;
    logic [XLEN-1:0]  data_q, data_next;
    logic [4:0]       lat_reg, lat_reg_next;
    logic [XLEN-1:0]  lat_value, lat_value_next;
    logic [TMO_W-1:0] lat_tmo, lat_tmo_next;
    logic [TMO_W-1:0] cnt, cnt_next;
    logic [4:0]       rd_addr;
    logic [XLEN-1:0]  rd_data;
    logic             hit;

    shadow_regfile #(.XLEN(XLEN), .NREGS(NREGS), .AW(5)) u_shadow (
        .clk   (clk),
        .rst   (rst),
        .we    (wb_we),
        .waddr (wb_addr),
        .wdata (wb_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // The single read port follows the live request in IDLE, the latched one otherwise.
    assign rd_addr = (state == ST_IDLE) ? req_reg : lat_reg;
    assign hit     = (state == ST_IDLE) ? (rd_data == req_value) : (rd_data == lat_value);

    always_comb begin
        state_next     = state;
        status_next    = status_q;
        data_next      = data_q;
        lat_reg_next   = lat_reg;
        lat_value_next = lat_value;
        lat_tmo_next   = lat_tmo;
        cnt_next       = cnt;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    lat_reg_next   = req_reg;
                    lat_value_next = req_value;
                    lat_tmo_next   = req_timeout;
                    cnt_next       = '0;
                    if (req_op == DBG_OP_READ) begin
                        state_next  = ST_RESP;
                        status_next = DBG_OK;
                        data_next   = rd_data;
                    end else if (hit) begin
                        state_next  = ST_RESP;
                        status_next = DBG_MATCH;
                        data_next   = rd_data;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (hit) begin
                    state_next  = ST_RESP;
                    status_next = DBG_MATCH;
                    data_next   = rd_data;
                end else if (lat_tmo != '0 && cnt == lat_tmo - TMO_W'(1)) begin
                    state_next  = ST_RESP;
                    status_next = DBG_TIMEOUT;
                    data_next   = rd_data;
                end else if (cnt != '1) begin
                    cnt_next = cnt + TMO_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            status_q  <= DBG_OK;
            data_q    <= '0;
            lat_reg   <= '0;
            lat_value <= '0;
            lat_tmo   <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_next;
            status_q  <= status_next;
            data_q    <= data_next;
            lat_reg   <= lat_reg_next;
            lat_value <= lat_value_next;
            lat_tmo   <= lat_tmo_next;
            cnt       <= cnt_next;
        end
    end

    assign req_ready  = (state == ST_IDLE);
    assign rsp_valid  = (state == ST_RESP);
    assign rsp_data   = data_q;
    assign rsp_status = status_q;

endmodule

// File: tb/tb_regfile_debug_responder.sv
// Bench for regfile_debug_responder: scoreboard of expected {status,data}
// pushed at request time and popped when the response appears.
module tb_regfile_debug_responder;
    import riscv151_dbg_pkg::*;

    localparam int XLEN  = 32;
    localparam int TMO_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             wb_we = 1'b0;
    logic [4:0]       wb_addr = '0;
    logic [XLEN-1:0]  wb_data = '0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_op = 1'b0;
    logic [4:0]       req_reg = '0;
    logic [XLEN-1:0]  req_value = '0;
    logic [TMO_W-1:0] req_timeout = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [XLEN-1:0]  rsp_data;
    logic [1:0]       rsp_status;

    logic [XLEN+1:0]  exp_q[$];
    logic [XLEN-1:0]  model_rf [32];
    int n_checks = 0;
    int n_fail   = 0;

    regfile_debug_responder #(.XLEN(XLEN), .NREGS(32), .TMO_W(TMO_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_reg     (req_reg),
        .req_value   (req_value),
        .req_timeout (req_timeout),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_status  (rsp_status)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model_rf[i] = '0;
    endtask

    task automatic wb_set(input logic [4:0] a, input logic [XLEN-1:0] d);
        wb_we   = 1'b1;
        wb_addr = a;
        wb_data = d;
        if (a != 5'd0) model_rf[a] = d;
    endtask

    task automatic push_exp(input logic [1:0] st, input logic [XLEN-1:0] d);
        exp_q.push_back({st, d});
    endtask

    // Called at a falling edge; presents the request for exactly one rising edge.
    task automatic issue(input string tag, input logic op, input logic [4:0] r,
                         input logic [XLEN-1:0] v, input logic [TMO_W-1:0] t);
        check({tag, " req_ready"}, XLEN'(req_ready), XLEN'(1));
        req_valid   = 1'b1;
        req_op      = op;
        req_reg     = r;
        req_value   = v;
        req_timeout = t;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Waits for rsp_valid, compares against the scoreboard, optionally holds
    // rsp_ready low while x1 keeps changing, then completes the handshake.
    task automatic await_rsp(input string tag, input int exp_wait, input int hold);
        int waited;
        logic [XLEN+1:0] e;
        waited = 0;
        while (!rsp_valid && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " rsp_valid"}, XLEN'(rsp_valid), XLEN'(1));
        if (exp_wait >= 0) check({tag, " latency"}, XLEN'(waited), XLEN'(exp_wait));
        check({tag, " scoreboard"}, XLEN'(exp_q.size() != 0), XLEN'(1));
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        check({tag, " data"}, rsp_data, e[XLEN-1:0]);
        check({tag, " status"}, XLEN'(rsp_status), XLEN'(e[XLEN+1:XLEN]));
        for (int i = 0; i < hold; i++) begin
            wb_set(5'd1, XLEN'($urandom));
            @(negedge clk);
            check({tag, " hold valid"}, XLEN'(rsp_valid), XLEN'(1));
            check({tag, " hold req_ready"}, XLEN'(req_ready), XLEN'(0));
            check({tag, " hold data"}, rsp_data, e[XLEN-1:0]);
            check({tag, " hold status"}, XLEN'(rsp_status), XLEN'(e[XLEN+1:XLEN]));
        end
        wb_we = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, " rsp_valid drop"}, XLEN'(rsp_valid), XLEN'(0));
        check({tag, " idle req_ready"}, XLEN'(req_ready), XLEN'(1));
    endtask

    task automatic do_read(input string tag, input logic [4:0] r);
        push_exp(DBG_OK, (r == 5'd0) ? '0 : model_rf[r]);
        issue(tag, DBG_OP_READ, r, '0, '0);
        wb_we = 1'b0;
        await_rsp(tag, 0, 0);
    endtask

    // ---------------- stimulus ----------------
    logic [XLEN-1:0] v;
    logic [4:0]      r;

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset req_ready", XLEN'(req_ready), XLEN'(1));
        check("reset rsp_valid", XLEN'(rsp_valid), XLEN'(0));
        check("reset rsp_data", rsp_data, '0);
        check("reset rsp_status", XLEN'(rsp_status), XLEN'(0));

        // READ with no writes, then x0 write ignored (stored and bypassed)
        do_read("read_x5", 5'd5);
        wb_set(5'd0, 32'hDEAD);
        do_read("read_x0", 5'd0);
        do_read("read_x0_again", 5'd0);

        // same-cycle write bypass, then stored value
        wb_set(5'd1, 32'd300);
        do_read("bypass_x1", 5'd1);
        do_read("stored_x1", 5'd1);

        // WAIT_EQ, no timeout, match written after 50 cycles
        push_exp(DBG_MATCH, 32'd1);
        issue("wait_forever", DBG_OP_WAIT_EQ, 5'd20, 32'd1, '0);
        repeat (50) @(negedge clk);
        check("wait_forever pending", XLEN'(rsp_valid), XLEN'(0));
        check("wait_forever req_ready", XLEN'(req_ready), XLEN'(0));
        wb_set(5'd20, 32'd1);
        @(negedge clk);
        wb_we = 1'b0;
        await_rsp("wait_forever", 0, 0);

        // WAIT_EQ immediate match in the accept cycle
        push_exp(DBG_MATCH, 32'd1);
        issue("wait_immediate", DBG_OP_WAIT_EQ, 5'd20, 32'd1, 16'd5);
        await_rsp("wait_immediate", 0, 0);

        // timeout after exactly 10 WAIT cycles
        push_exp(DBG_TIMEOUT, 32'd1);
        issue("wait_timeout", DBG_OP_WAIT_EQ, 5'd20, 32'd2, 16'd10);
        await_rsp("wait_timeout", 10, 0);

        // match lands in the final WAIT cycle: MATCH wins
        push_exp(DBG_MATCH, 32'd2);
        issue("wait_last", DBG_OP_WAIT_EQ, 5'd20, 32'd2, 16'd10);
        repeat (9) @(negedge clk);
        check("wait_last pending", XLEN'(rsp_valid), XLEN'(0));
        wb_set(5'd20, 32'd2);
        @(negedge clk);
        wb_we = 1'b0;
        await_rsp("wait_last", 0, 0);

        // timeout of one cycle
        push_exp(DBG_TIMEOUT, 32'd2);
        issue("wait_tmo1", DBG_OP_WAIT_EQ, 5'd20, 32'd7, 16'd1);
        await_rsp("wait_tmo1", 1, 0);

        // response held for 5 cycles while x1 changes
        push_exp(DBG_OK, model_rf[1]);
        issue("hold_x1", DBG_OP_READ, 5'd1, '0, '0);
        await_rsp("hold_x1", 0, 5);
        do_read("after_hold_x1", 5'd1);

        // random reads with optional concurrent writes
        for (int i = 0; i < 16; i++) begin
            r = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1)
                wb_set(($urandom_range(0, 1) == 1) ? r : 5'($urandom_range(0, 31)), XLEN'($urandom));
            do_read("rand_read", r);
        end

        // reset during WAIT aborts the request and clears the shadow
        v = model_rf[3] + 32'd1;
        issue("abort_wait", DBG_OP_WAIT_EQ, 5'd3, v, '0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort in_reset rsp_valid", XLEN'(rsp_valid), XLEN'(0));
        check("abort in_reset rsp_data", rsp_data, '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        check("abort req_ready", XLEN'(req_ready), XLEN'(1));
        repeat (5) @(negedge clk);
        check("abort no rsp", XLEN'(rsp_valid), XLEN'(0));
        for (int i = 0; i < 32; i++) do_read("post_reset_read", 5'(i));

        check("scoreboard drained", XLEN'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_debug_responder.md
Name: regfile_debug_responder

Overview:
Synthesizable debug responder that snoops the Riscv151 register-file write port and keeps a shadow copy of x0..x31. A host-side initiator (UART debug bridge or bench) issues READ or WAIT_EQ requests over valid/ready and receives a single response per request. WAIT_EQ is the hardware equivalent of "run until register N holds V", with a cycle timeout. Sits beside the CPU core; has no effect on CPU execution.

Parameters:
XLEN, 32, register/data width
NREGS, 32, number of architectural registers (address width = 5)
TMO_W, 16, width of timeout request field and cycle counter

Ports:
clk  input  1  core clock
rst  input  1  asynchronous reset, active-low (asserted at 0)
wb_we  input  1  CPU regfile write enable
wb_addr  input  5  CPU regfile write address
wb_data  input  XLEN  CPU regfile write data
req_valid  input  1  request valid
req_ready  output  1  request accepted when req_valid && req_ready
req_op  input  1  0 = READ, 1 = WAIT_EQ
req_reg  input  5  register number
req_value  input  XLEN  expected value (WAIT_EQ only)
req_timeout  input  TMO_W  max wait cycles; 0 = wait forever
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
rsp_data  output  XLEN  register value at completion
rsp_status  output  2  0 = OK (READ), 1 = MATCH, 2 = TIMEOUT

Behaviour:
- Reset (rst=0, async): state IDLE, req_ready=1 after deassertion, rsp_valid=0, rsp_data=0, rsp_status=0, timeout counter=0, all shadow entries=0. Reset mid-WAIT or mid-RESP aborts the transaction; no response emitted.
- Shadow: on posedge clk, wb_we && wb_addr!=0 writes wb_data to shadow[wb_addr]. Writes to x0 ignored; shadow[0] reads 0 always.
- Effective value eff(r) = wb_data if (wb_we && wb_addr==r && r!=0) this cycle, else shadow[r] (write bypass).
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On accept: latch req_reg, req_value, req_timeout.
  - READ: -> RESP next edge, rsp_data=eff(req_reg), status OK. Latency 1 cycle.
  - WAIT_EQ with eff(req_reg)==req_value in accept cycle: -> RESP, status MATCH (latency 1).
  - Otherwise: -> WAIT, counter=0.
- WAIT: req_ready=0. Each cycle compare eff(latched reg) to latched value.
  - Match: -> RESP, status MATCH, rsp_data=matched value.
  - Else if timeout!=0 and counter==timeout-1: -> RESP, status TIMEOUT, rsp_data=eff(reg).
  - Else counter+1 (saturates at all-ones when timeout==0; never wraps into a false timeout).
  - Match and timeout in same cycle: MATCH wins.
- RESP: rsp_valid=1, req_ready=0; rsp_data/rsp_status stable until handshake. On rsp_ready -> IDLE next edge (rsp_valid falls). No back-to-back accept in the handshake cycle (1 bubble).
- Shadow keeps updating in all states, including RESP; rsp_data does not change after entering RESP.
- Register outputs only; no combinational path from req_* to rsp_*.

Decomposition:
- Package riscv151_dbg_pkg: op encodings (DBG_OP_READ, DBG_OP_WAIT_EQ), status codes (DBG_OK, DBG_MATCH, DBG_TIMEOUT), FSM state encodings.
- Sub-module shadow_regfile: 32xXLEN array, x0 hardwired zero, one write port, one bypassed read port.

Test Plan:
- Reset then READ x5 with no writes -> rsp after 1 cycle, data 0, status OK; READ x0 after wb write x0=0xDEAD -> data 0.
- wb write x1=300, READ x1 in the same cycle as the write -> data 300 (bypass), status OK.
- WAIT_EQ x20=1, timeout 0; write x20=1 after 50 cycles -> rsp_valid in the cycle after the write, status MATCH, data 1.
- WAIT_EQ x20=2, timeout 10, no writes -> TIMEOUT after exactly 10 WAIT cycles, data = current x20; match written in cycle 10 -> MATCH.
- Hold rsp_ready=0 for 5 cycles while x1 keeps changing -> rsp_data/status stable, req_ready=0; release -> IDLE, next request accepted the following cycle.
- Assert rst during WAIT -> rsp_valid stays 0, shadow all 0, req_ready=1 after release.
